// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA modular-exponentiation unit.
package rsa_pkg;
  localparam int unsigned RSA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MUL,
    DONE
  } rsa_state_e;
endpackage

// File: rtl/rsa_unit_if.sv
// Control/data bundle between the control FSM (master) and rsa_unit (slave).
interface rsa_unit_if #(
  parameter int unsigned WIDTH = rsa_pkg::RSA_WIDTH
);
  logic             en_rsa;
  logic             rst_rsa;
  logic [WIDTH-1:0] plain_text;
  logic [WIDTH-1:0] exp_key;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] cipher_text;
  logic             eoc_rsa_unit;
  logic             err;

  modport master (
    output en_rsa, rst_rsa, plain_text, exp_key, modulus,
    input  cipher_text, eoc_rsa_unit, err
  );

  modport slave (
    input  en_rsa, rst_rsa, plain_text, exp_key, modulus,
    output cipher_text, eoc_rsa_unit, err
  );
endinterface

// File: rtl/rsa_modmul.sv
// Interleaved MSB-first modular multiplier: prod = a*b mod m in WIDTH enabled cycles.
// The start cycle already consumes a[WIDTH-1]; done/prod are valid combinationally
// during the last cycle so the caller can capture on the WIDTH-th edge.
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ce,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH+1:0] acc_q, acc_d, acc_in, s0, s1, s2;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             a_bit;

  // One shift-add-reduce step; acc stays below m so two subtractions suffice.
  always_comb begin
    acc_in = start ? '0 : acc_q;
    a_bit  = start ? a[WIDTH-1] : a_q[WIDTH-1];
    s0     = (acc_in << 1) + (a_bit ? {2'b00, b} : '0);
    s1     = (s0 >= {2'b00, m}) ? s0 - {2'b00, m} : s0;
    s2     = (s1 >= {2'b00, m}) ? s1 - {2'b00, m} : s1;
    prod   = s2[WIDTH-1:0];
    busy   = busy_q;
    done   = busy_q && (cnt_q == LAST);
  end

  // Next-state for accumulator, multiplier shift register and bit counter.
  always_comb begin
    acc_d  = acc_q;
    a_d    = a_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (clr) begin
      acc_d  = '0;
      a_d    = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (ce) begin
      if (start) begin
        acc_d  = s2;
        a_d    = a << 1;
        cnt_d  = CW'(1);
        busy_d = 1'b1;
      end else if (busy_q) begin
        a_d = a_q << 1;
        if (cnt_q == LAST) begin
          acc_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b0;
        end else begin
          acc_d = s2;
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      acc_q  <= '0;
      a_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      a_q    <= a_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: rtl/rsa_unit.sv
// C = P^E mod M by right-to-left square-and-multiply, constant time in E.
module rsa_unit
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = RSA_WIDTH
) (
  input  logic   clk,
  input  logic   rstb,
  input  logic   ena,
  rsa_unit_if.slave bus
);
  localparam int unsigned BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  rsa_state_e       state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d, e_q, e_d, m_q, m_d;
  logic [WIDTH-1:0] res_q, res_d, base_q, base_d, cipher_q, cipher_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             eoc_q, eoc_d, err_q, err_d;

  logic             mm_ce, mm_clr, mm_start, step_done;
  logic             sq_busy, sq_done, mul_busy, mul_done;
  logic [WIDTH-1:0] sq_prod, mul_prod;

  // Both multipliers run in lockstep; pausing or soft reset reaches them too.
  always_comb begin
    mm_clr    = ena && !bus.rst_rsa;
    mm_ce     = ena && bus.rst_rsa && bus.en_rsa && (state_q == MUL);
    mm_start  = (state_q == MUL) && !(sq_busy || mul_busy);
    step_done = sq_done && mul_done;
  end

  rsa_modmul #(.WIDTH(WIDTH)) u_square (
    .clk(clk), .rstb(rstb), .ce(mm_ce), .clr(mm_clr), .start(mm_start),
    .a(base_q), .b(base_q), .m(m_q),
    .busy(sq_busy), .done(sq_done), .prod(sq_prod)
  );

  rsa_modmul #(.WIDTH(WIDTH)) u_multiply (
    .clk(clk), .rstb(rstb), .ce(mm_ce), .clr(mm_clr), .start(mm_start),
    .a(res_q), .b(base_q), .m(m_q),
    .busy(mul_busy), .done(mul_done), .prod(mul_prod)
  );

  // Control FSM and datapath next-state; soft reset wins over run enable.
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    e_d      = e_q;
    m_d      = m_q;
    res_d    = res_q;
    base_d   = base_q;
    bit_d    = bit_q;
    cipher_d = cipher_q;
    eoc_d    = eoc_q;
    err_d    = err_q;
    if (ena) begin
      if (!bus.rst_rsa) begin
        state_d  = IDLE;
        p_d      = '0;
        e_d      = '0;
        m_d      = '0;
        res_d    = '0;
        base_d   = '0;
        bit_d    = '0;
        cipher_d = '0;
        eoc_d    = 1'b0;
        err_d    = 1'b0;
      end else begin
        case (state_q)
          IDLE: if (bus.en_rsa) begin
            p_d     = bus.plain_text;
            e_d     = bus.exp_key;
            m_d     = bus.modulus;
            state_d = LOAD;
          end
          LOAD: if (bus.en_rsa) begin
            if ((m_q < WIDTH'(2)) || (p_q >= m_q)) begin
              state_d  = DONE;
              err_d    = 1'b1;
              eoc_d    = 1'b1;
              cipher_d = '0;
            end else begin
              state_d = MUL;
              res_d   = WIDTH'(1);
              base_d  = p_q;
              bit_d   = '0;
            end
          end
          MUL: if (bus.en_rsa && step_done) begin
            // Exponent is consumed LSB first by shifting e_q right each step.
            base_d = sq_prod;
            if (e_q[0]) res_d = mul_prod;
            e_d = e_q >> 1;
            if (bit_q == LAST_BIT) begin
              state_d  = DONE;
              eoc_d    = 1'b1;
              cipher_d = e_q[0] ? mul_prod : res_q;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= IDLE;
      p_q      <= '0;
      e_q      <= '0;
      m_q      <= '0;
      res_q    <= '0;
      base_q   <= '0;
      bit_q    <= '0;
      cipher_q <= '0;
      eoc_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      e_q      <= e_d;
      m_q      <= m_d;
      res_q    <= res_d;
      base_q   <= base_d;
      bit_q    <= bit_d;
      cipher_q <= cipher_d;
      eoc_q    <= eoc_d;
      err_q    <= err_d;
    end
  end

  assign bus.cipher_text  = cipher_q;
  assign bus.eoc_rsa_unit = eoc_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_rsa_unit.sv
// Self-checking bench for rsa_unit: latency-level reference model plus directed vectors.
module tb_rsa_unit;
  import rsa_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rstb;
  logic ena;
  logic cmp_on;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rsa_unit_if #(.WIDTH(W)) bus ();

  rsa_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rstb(rstb),
    .ena(ena),
    .bus(bus)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic longint ref_modexp(input longint p, input longint e, input longint m);
    longint r;
    r = 1 % m;
    for (longint i = 0; i < e; i++) r = (r * p) % m;
    return r;
  endfunction

  function automatic bit ref_bad(input longint p, input longint m);
    return (m < 2) || (p >= m);
  endfunction

  // Reference model: result computed at start, revealed after a fixed count of running edges.
  logic         m_run, m_done, m_eoc, m_err, m_perr;
  logic [W-1:0] m_c, m_pc;
  int           m_left;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_run <= 0; m_done <= 0; m_eoc <= 0; m_err <= 0; m_c <= '0;
      m_perr <= 0; m_pc <= '0; m_left <= 0;
    end else if (ena) begin
      if (!bus.rst_rsa) begin
        m_run <= 0; m_done <= 0; m_eoc <= 0; m_err <= 0; m_c <= '0;
      end else if (!m_run && !m_done) begin
        if (bus.en_rsa) begin
          m_run  <= 1;
          m_perr <= ref_bad(bus.plain_text, bus.modulus);
          m_pc   <= ref_bad(bus.plain_text, bus.modulus) ? '0 :
                    W'(ref_modexp(bus.plain_text, bus.exp_key, bus.modulus));
          m_left <= ref_bad(bus.plain_text, bus.modulus) ? 1 : W * W + 1;
        end
      end else if (m_run && bus.en_rsa) begin
        if (m_left == 1) begin
          m_run <= 0; m_done <= 1; m_eoc <= 1; m_err <= m_perr; m_c <= m_pc;
        end else begin
          m_left <= m_left - 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rstb && cmp_on) begin
      check("cyc_eoc", bus.eoc_rsa_unit, m_eoc);
      check("cyc_err", bus.err, m_err);
      check("cyc_cipher", bus.cipher_text, m_c);
    end
  end

  task automatic soft_clear(input string name);
    @(negedge clk);
    bus.rst_rsa = 1'b0;
    bus.en_rsa  = 1'b0;
    @(posedge clk); #1;
    check({name, "_clr_eoc"}, bus.eoc_rsa_unit, 0);
    check({name, "_clr_c"}, bus.cipher_text, 0);
    @(negedge clk);
    bus.rst_rsa = 1'b1;
  endtask

  task automatic run(input logic [W-1:0] p, input logic [W-1:0] e, input logic [W-1:0] m,
                     input logic [W-1:0] exp_c, input logic exp_err, input int exp_edges,
                     input int pause_at, input int pause_len, input bit keep, input string name);
    int n;
    bit seen;
    @(negedge clk);
    bus.plain_text = p;
    bus.exp_key    = e;
    bus.modulus    = m;
    bus.en_rsa     = 1'b1;
    n    = 0;
    seen = 0;
    while (!seen && n < 300) begin
      @(posedge clk); n++; #1;
      if (n == 1) begin
        // Operands must have been latched; scramble them.
        bus.plain_text = ~p;
        bus.exp_key    = ~e;
        bus.modulus    = ~m;
      end
      if (bus.eoc_rsa_unit) seen = 1;
      else if (pause_len > 0 && n == pause_at) begin
        @(negedge clk);
        bus.en_rsa = 1'b0;
        repeat (pause_len) @(negedge clk);
        bus.en_rsa = 1'b1;
        n += pause_len;
      end
    end
    check({name, "_eoc_seen"}, seen, 1);
    check({name, "_edges"}, n, exp_edges);
    check({name, "_cipher"}, bus.cipher_text, exp_c);
    check({name, "_err"}, bus.err, exp_err);
    if (!keep) soft_clear(name);
  endtask

  task automatic start_only(input logic [W-1:0] p, input logic [W-1:0] e, input logic [W-1:0] m);
    @(negedge clk);
    bus.plain_text = p;
    bus.exp_key    = e;
    bus.modulus    = m;
    bus.en_rsa     = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    rstb = 1'b0; ena = 1'b1; cmp_on = 1'b0;
    bus.en_rsa = 1'b0; bus.rst_rsa = 1'b1;
    bus.plain_text = '0; bus.exp_key = '0; bus.modulus = '0;

    check("model_7_3_33", ref_modexp(7, 3, 33), 13);
    check("model_2_10_251", ref_modexp(2, 10, 251), 20);
    check("model_254_255_255", ref_modexp(254, 255, 255), 254);
    check("model_5_0_11", ref_modexp(5, 0, 11), 1);
    check("model_0_5_11", ref_modexp(0, 5, 11), 0);

    repeat (2) @(posedge clk); #1;
    check("rst_eoc", bus.eoc_rsa_unit, 0);
    check("rst_err", bus.err, 0);
    check("rst_cipher", bus.cipher_text, 0);
    @(negedge clk);
    rstb = 1'b1; cmp_on = 1'b1;

    run(7, 3, 33, 13, 0, 66, 0, 0, 0, "p7e3m33");
    run(2, 10, 251, 20, 0, 66, 0, 0, 0, "p2e10m251");
    run(254, 255, 255, 254, 0, 66, 0, 0, 0, "p254e255m255");
    run(5, 0, 11, 1, 0, 66, 0, 0, 0, "e0");
    run(0, 5, 11, 0, 0, 66, 0, 0, 0, "p0");
    run(0, 0, 1, 0, 1, 2, 0, 0, 0, "m1");
    run(200, 5, 100, 0, 1, 2, 0, 0, 0, "p_ge_m");
    run(7, 3, 33, 13, 0, 76, 20, 10, 1, "pause");

    // Clock enable low masks the soft reset; DONE holds.
    @(negedge clk);
    ena = 1'b0; bus.rst_rsa = 1'b0;
    repeat (3) @(negedge clk);
    check("ena0_eoc", bus.eoc_rsa_unit, 1);
    check("ena0_cipher", bus.cipher_text, 13);
    ena = 1'b1; bus.en_rsa = 1'b0;
    @(posedge clk); #1;
    check("ena1_clr_eoc", bus.eoc_rsa_unit, 0);
    check("ena1_clr_cipher", bus.cipher_text, 0);
    @(negedge clk);
    bus.rst_rsa = 1'b1;

    // Soft reset mid-MUL abandons the operation.
    start_only(2, 10, 251);
    bus.rst_rsa = 1'b0; bus.en_rsa = 1'b0;
    @(negedge clk);
    bus.rst_rsa = 1'b1;
    repeat (80) @(negedge clk);
    check("softrst_eoc", bus.eoc_rsa_unit, 0);
    check("softrst_cipher", bus.cipher_text, 0);
    run(2, 10, 251, 20, 0, 66, 0, 0, 1, "after_softrst");

    // Async reset in DONE clears outputs without a clock edge.
    @(posedge clk); #2;
    rstb = 1'b0; #1;
    check("arst_done_eoc", bus.eoc_rsa_unit, 0);
    check("arst_done_cipher", bus.cipher_text, 0);
    @(negedge clk);
    rstb = 1'b1; bus.en_rsa = 1'b0;

    // Async reset mid-MUL, then a fresh operation.
    start_only(254, 255, 255);
    @(posedge clk); #2;
    rstb = 1'b0; #1;
    check("arst_mul_eoc", bus.eoc_rsa_unit, 0);
    check("arst_mul_err", bus.err, 0);
    @(negedge clk);
    rstb = 1'b1; bus.en_rsa = 1'b0;
    run(7, 3, 33, 13, 0, 66, 0, 0, 0, "after_arst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rsa_unit.md
RSA_UNIT -- requirements
Module: rsa_unit

Interface
REQ-001 Parameter WIDTH SHALL be: default 8; operand/modulus width in bits.
REQ-002 Port clk SHALL be: input, 1 bit, single clock; all state changes on its rising edge.
REQ-003 Port rstb SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-004 Port ena SHALL be: input, 1 bit, clock enable; with ena=0 all registers hold.
REQ-005 Port en_rsa SHALL be: input, 1 bit, run enable from the control FSM.
REQ-006 Port rst_rsa SHALL be: input, 1 bit, synchronous active-low soft reset from the control FSM.
REQ-007 Port plain_text SHALL be: input, WIDTH bits, base P.
REQ-008 Port exp_key SHALL be: input, WIDTH bits, exponent E.
REQ-009 Port modulus SHALL be: input, WIDTH bits, modulus M.
REQ-010 Port cipher_text SHALL be: output, WIDTH bits, result C = P^E mod M.
REQ-011 Port eoc_rsa_unit SHALL be: output, 1 bit, end of conversion.
REQ-012 Port err SHALL be: output, 1 bit, invalid operands flag.

Function
REQ-013 States SHALL be IDLE, LOAD, MUL, DONE; advances occur only on edges with ena=1.
REQ-014 With rst_rsa=0 sampled (ena=1), the block SHALL go to IDLE and clear cipher_text, eoc_rsa_unit and err; rst_rsa takes priority over en_rsa.
REQ-015 IDLE->LOAD SHALL occur when en_rsa=1 and rst_rsa=1 are sampled; P, E, M are latched on this edge and ignored afterwards.
REQ-016 LOAD SHALL check operands: M<2 or P>=M -> DONE with err=1, cipher_text=0; otherwise -> MUL with result=1, base=P, bit index=0.
REQ-017 MUL SHALL process E LSB first, one bit per WIDTH-cycle step, using right-to-left square-and-multiply: base*base mod M and result*base mod M are both computed every step in parallel; result is updated only if the current E bit is 1 (constant time regardless of E).
REQ-018 After the step for bit WIDTH-1 completes, MUL->DONE SHALL occur, and cipher_text SHALL be loaded with the final result on that edge.
REQ-019 eoc_rsa_unit SHALL be a registered output, high exactly in DONE; it first reads high after the WIDTH*WIDTH+2nd enabled edge counting the start-sampling edge as 1 (66 for WIDTH=8); on the error path, after the 2nd edge.
REQ-020 DONE SHALL hold eoc_rsa_unit, err and cipher_text stable until rst_rsa=0 is sampled; en_rsa in DONE is ignored.
REQ-021 en_rsa=0 during LOAD or MUL SHALL freeze all state (pause); the operation resumes when en_rsa returns to 1, with latency extended by the paused cycles.
REQ-022 The modular multiply SHALL be interleaved MSB-first: acc = 2*acc + (a_bit ? b : 0), then subtract M at most twice so that acc < M; acc width is WIDTH+2 with no overflow.
REQ-023 E=0 with valid operands SHALL yield C=1; P=0 with E>0 SHALL yield C=0.
REQ-024 ena=0 with rst_rsa=0 SHALL not reset the block (soft reset is sampled only on enabled edges).

Reset
REQ-025 rstb=0 SHALL immediately force IDLE, cipher_text=0, eoc_rsa_unit=0, err=0 and clear all internal registers, including mid-operation.
REQ-026 After rstb deasserts, the block SHALL wait in IDLE for a start condition (REQ-015).

Structure
REQ-027 Package rsa_pkg SHALL hold the state enum (IDLE, LOAD, MUL, DONE) and the WIDTH default constant.
REQ-028 Sub-module rsa_modmul (one WIDTH-cycle interleaved modular multiplier with start/done) SHALL be instantiated twice, once for square and once for multiply.

Verification
REQ-029 P=7, E=3, M=33, start -> C=13, eoc_rsa_unit high after edge 66, err=0.
REQ-030 P=2, E=10, M=251 -> C=20; P=254, E=255, M=255 -> C=254.
REQ-031 P=5, E=0, M=11 -> C=1; P=0, E=5, M=11 -> C=0.
REQ-032 M=1 -> err=1, C=0, eoc after edge 2; P=200, M=100 -> err=1.
REQ-033 en_rsa low for 10 cycles mid-MUL -> correct C, eoc after edge 76; rst_rsa=0 mid-MUL -> IDLE, outputs 0.
REQ-034 rstb asserted asynchronously mid-MUL -> outputs 0 immediately; next start computes correctly.
